// File: rtl/conv33_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting one registered window and enable pulse per unpadded output position.
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic signed [DATA_WIDTH-1:0] data_0_0,
  output logic signed [DATA_WIDTH-1:0] data_0_1,
  output logic signed [DATA_WIDTH-1:0] data_0_2,
  output logic signed [DATA_WIDTH-1:0] data_1_0,
  output logic signed [DATA_WIDTH-1:0] data_1_1,
  output logic signed [DATA_WIDTH-1:0] data_1_2,
  output logic signed [DATA_WIDTH-1:0] data_2_0,
  output logic signed [DATA_WIDTH-1:0] data_2_1,
  output logic signed [DATA_WIDTH-1:0] data_2_2,
  output logic                         win_valid,
  output logic [15:0]                  win_row,
  output logic [15:0]                  win_col,
  output logic                         busy,
  output logic                         frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  state_t      state, state_nxt;
  logic [15:0] row, col;
  logic [CW-1:0] col_idx;
  logic        accept, qualify;

  logic signed [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic signed [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic signed [DATA_WIDTH-1:0] win_p0  [3][3];
  logic signed [DATA_WIDTH-1:0] win_nxt [3][3];
  logic signed [DATA_WIDTH-1:0] data_p1 [3][3];

  assign col_idx = col[CW-1:0];
  assign accept  = pix_valid && (state == RUN);
  assign qualify = accept && (row >= 16'd2) && (col >= 16'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (accept && row == LAST_ROW && col == LAST_COL) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // p0: line buffers read old contents before the write lands (read-before-write)
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_idx] <= lb0[col_idx];
      lb0[col_idx] <= pix_in;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win_p0[r][1];
      win_nxt[r][1] = win_p0[r][2];
    end
    win_nxt[0][2] = lb1[col_idx];
    win_nxt[1][2] = lb0[col_idx];
    win_nxt[2][2] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (accept) win_p0 <= win_nxt;
  end

  // p1: registered window outputs, updated only on qualifying accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          data_p1[r][c] <= '0;
    end else begin
      win_valid <= qualify;
      if (qualify) begin
        data_p1 <= win_nxt;
        win_row <= row - 16'd2;
        win_col <= col - 16'd2;
      end
    end
  end

  assign data_0_0 = data_p1[0][0];
  assign data_0_1 = data_p1[0][1];
  assign data_0_2 = data_p1[0][2];
  assign data_1_0 = data_p1[1][0];
  assign data_1_1 = data_p1[1][1];
  assign data_1_2 = data_p1[1][2];
  assign data_2_0 = data_p1[2][0];
  assign data_2_1 = data_p1[2][1];
  assign data_2_2 = data_p1[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Bench for conv33_window_gen on a 5x4 plane: a frame-level image model predicts
// every output each cycle; literal checks pin the first/last/wrap windows.
module tb_conv33_window_gen;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic signed [DW-1:0] pix_in = '0;
  logic pix_ready, win_valid, busy, frame_done;
  logic [15:0] win_row, win_col;
  logic signed [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;

  conv33_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .data_0_0(d00), .data_0_1(d01), .data_0_2(d02),
    .data_1_0(d10), .data_1_1(d11), .data_1_2(d12),
    .data_2_0(d20), .data_2_1(d21), .data_2_2(d22),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 receiving pixels, 2 frame finished
  int m_phase = 0;
  int m_n = 0;
  int img [H][W];
  int e_valid = 0, e_row = 0, e_col = 0;
  int e_win [9] = '{default: 0};

  always @(posedge clk) begin : model
    int r, c;
    if (rst) begin
      m_phase = 0; m_n = 0; e_valid = 0; e_row = 0; e_col = 0;
      for (int t = 0; t < 9; t++) e_win[t] = 0;
    end else begin
      e_valid = 0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_n = 0; end
        1: if (pix_valid) begin
          r = m_n / W;
          c = m_n % W;
          img[r][c] = int'(pix_in);
          if (r >= 2 && c >= 2) begin
            e_valid = 1; e_row = r - 2; e_col = c - 2;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                e_win[i*3+j] = img[r-2+i][c-2+j];
          end
          m_n++;
          if (m_n == W*H) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Window log of observed pulses, for literal checks
  int lg_d[$];
  int lg_row[$], lg_col[$], lg_done[$];

  always @(negedge clk) begin : cmp
    int dv [9];
    dv = '{int'(d00), int'(d01), int'(d02), int'(d10), int'(d11), int'(d12),
           int'(d20), int'(d21), int'(d22)};
    if (rst) begin
      chk("rst_win_valid", int'(win_valid), 0);
      chk("rst_pix_ready", int'(pix_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_win_row", int'(win_row), 0);
      chk("rst_win_col", int'(win_col), 0);
      for (int t = 0; t < 9; t++) chk($sformatf("rst_data_%0d_%0d", t/3, t%3), dv[t], 0);
    end else begin
      chk("win_valid", int'(win_valid), e_valid);
      chk("pix_ready", int'(pix_ready), (m_phase == 1) ? 1 : 0);
      chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("frame_done", int'(frame_done), (m_phase == 2) ? 1 : 0);
      chk("win_row", int'(win_row), e_row);
      chk("win_col", int'(win_col), e_col);
      for (int t = 0; t < 9; t++) chk($sformatf("data_%0d_%0d", t/3, t%3), dv[t], e_win[t]);
      if (win_valid) begin
        for (int t = 0; t < 9; t++) lg_d.push_back(dv[t]);
        lg_row.push_back(int'(win_row));
        lg_col.push_back(int'(win_col));
        lg_done.push_back(int'(frame_done));
      end
    end
  end

  task automatic clear_log();
    lg_d.delete(); lg_row.delete(); lg_col.delete(); lg_done.delete();
  endtask

  // mode: 0 ramp row*W+col, 1 signed extremes, 2 random; gap: 0 none, 1 toggle, 2 random
  task automatic send_frame(input int mode, input int gap, input int abort_after, input int start_mid);
    int k, cyc, tog;
    bit acc;
    k = 0; cyc = 0; tog = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < W*H && cyc < 2000) begin
      case (mode)
        0: pix_in = DW'(k);
        1: pix_in = (k == 12) ? 8'sh7f : 8'sh80;
        default: pix_in = DW'($urandom);
      endcase
      case (gap)
        0: pix_valid = 1'b1;
        1: pix_valid = tog[0];
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      tog ^= 1;
      start = (start_mid != 0 && k == 7) ? 1'b1 : 1'b0;
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
      if (abort_after >= 0 && k == abort_after) begin
        pix_valid = 1'b0; start = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_data_2_2", int'(d22), 0);
        chk("abort_win_valid", int'(win_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    pix_valid = 1'b0; start = 1'b0;
    if (k < W*H) begin
      errors++; checks++;
      $display("FAIL frame_timeout: accepted %0d expected %0d", k, W*H);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_ramp(input string tag);
    int n, wr, wc;
    n = lg_row.size();
    chk({tag, "_n_windows"}, n, (W-2)*(H-2));
    for (int k = 0; k < n && k < 6; k++) begin
      wr = k / 3; wc = k % 3;
      chk({tag, "_row"}, lg_row[k], wr);
      chk({tag, "_col"}, lg_col[k], wc);
      chk({tag, "_done"}, lg_done[k], (k == 5) ? 1 : 0);
      for (int t = 0; t < 9; t++)
        chk($sformatf("%s_w%0d_tap%0d", tag, k, t), lg_d[k*9+t], (wr + t/3)*W + wc + t%3);
    end
  endtask

  initial begin
    int first [9];
    first = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pix_ready", int'(pix_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // pix_valid while idle must not be accepted
    pix_valid = 1'b1;
    pix_in = 8'sd99;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_pix_ready", int'(pix_ready), 0);
    chk("idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    pix_valid = 1'b0;

    clear_log();
    send_frame(0, 0, -1, 0);
    chk("t1_n_windows", lg_row.size(), 6);
    if (lg_row.size() == 6) begin
      for (int t = 0; t < 9; t++) chk($sformatf("t1_first_tap%0d", t), lg_d[t], first[t]);
      chk("t1_first_row", lg_row[0], 0);
      chk("t1_first_col", lg_col[0], 0);
      chk("t1_last_d22", lg_d[5*9+8], 19);
      chk("t1_last_row", lg_row[5], 1);
      chk("t1_last_col", lg_col[5], 2);
      chk("t1_last_done", lg_done[5], 1);
      chk("t1_wrap_d00", lg_d[3*9+0], 5);
      chk("t1_wrap_d22", lg_d[3*9+8], 17);
    end

    clear_log();
    send_frame(0, 1, -1, 0);
    check_ramp("toggle");

    clear_log();
    send_frame(1, 0, -1, 0);
    chk("ext_n_windows", lg_row.size(), 6);
    if (lg_row.size() > 0) begin
      for (int t = 0; t < 8; t++) chk($sformatf("ext_tap%0d", t), lg_d[t], -128);
      chk("ext_tap8", lg_d[8], 127);
    end

    send_frame(0, 0, 8, 0);
    clear_log();
    send_frame(0, 0, -1, 0);
    check_ramp("after_rst");

    clear_log();
    send_frame(0, 2, -1, 1);
    check_ramp("start_mid");

    for (int f = 0; f < 3; f++) begin
      clear_log();
      send_frame(2, 2, -1, 0);
      chk("rand_n_windows", lg_row.size(), 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
